// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one combinational ALU between
// the EX stage (requester 0) and the aux/debug port (requester 1).
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   reqN_valid/ready               request handshake (ready is combinational)
//   reqN_control/operand_1/2/shamt request payload
//   alu_control/operand_1/2/shamt  registered operation driven into the ALU
//   alu_result, alu_status         combinational ALU outputs
//   rsp_valid/ready                response handshake with backpressure
//   rsp_id/result/status           captured response payload
//   err_clear, err_count           saturating overflow/div_zero event counter
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_control,
    input  logic [31:0] req0_operand_1,
    input  logic [31:0] req0_operand_2,
    input  logic [4:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_control,
    input  logic [31:0] req1_operand_1,
    input  logic [31:0] req1_operand_2,
    input  logic [4:0]  req1_shamt,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_operand_1,
    output logic [31:0] alu_operand_2,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_result,
    input  logic [7:0]  alu_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [7:0]  rsp_status,
    input  logic        err_clear,
    output logic [7:0]  err_count
);
    localparam logic [3:0] OP_DIV     = 4'b0100;
    localparam logic [7:0] ST_DIVZERO = 8'h04;
    localparam logic [7:0] ERR_MAX    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rr_ptr;
    logic        id_q;
    logic        grant_valid;
    logic        grant_id;
    logic        div_zero;
    logic [31:0] cap_result;
    logic [7:0]  cap_status;
    logic        err_event;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant/ready decode; rr_ptr only breaks ties when both requesters are valid
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if ((state == IDLE) && !reset) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = rr_ptr;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
        req0_ready = grant_valid && !grant_id;
        req1_ready = grant_valid && grant_id;
    end

    // Divide by zero leaves the ALU result undefined; substitute a clean response
    always_comb begin
        div_zero   = (alu_control == OP_DIV) && (alu_operand_2 == 32'd0);
        cap_result = div_zero ? 32'd0 : alu_result;
        cap_status = div_zero ? ST_DIVZERO : alu_status;
        err_event  = cap_status[6] || cap_status[2];
    end

    // Issue registers, response capture and error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= 1'b0;
            id_q          <= 1'b0;
            alu_control   <= 4'd0;
            alu_operand_1 <= 32'd0;
            alu_operand_2 <= 32'd0;
            alu_shamt     <= 5'd0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_result    <= 32'd0;
            rsp_status    <= 8'd0;
            err_count     <= 8'd0;
        end else begin
            if (grant_valid) begin
                alu_control   <= grant_id ? req1_control   : req0_control;
                alu_operand_1 <= grant_id ? req1_operand_1 : req0_operand_1;
                alu_operand_2 <= grant_id ? req1_operand_2 : req0_operand_2;
                alu_shamt     <= grant_id ? req1_shamt     : req0_shamt;
                id_q          <= grant_id;
                rr_ptr        <= ~grant_id;
            end

            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= id_q;
                rsp_result <= cap_result;
                rsp_status <= cap_status;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end

            if (err_clear) begin
                err_count <= 8'd0;
            end else if ((state == EXEC) && err_event && (err_count != ERR_MAX)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters: requester 0 is the pipeline EX stage and requester 1 is the auxiliary/debug issue port. The block grants one requester with a valid/ready handshake and round-robin fairness, then drives a registered operation into the ALU. It captures the result and status one cycle later and returns them on a single response channel with backpressure. It also keeps a saturating count of arithmetic error events for software readout.

## Interface
- No parameters; widths are fixed by the ALU (4-bit control, 32-bit operands and result, 5-bit shamt, 8-bit status).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted this cycle when valid && ready
- req0_control, req1_control  in  4  ALU opcode
- req0_operand_1/2, req1_operand_1/2  in  32  operands
- req0_shamt, req1_shamt  in  5  shift amount
- alu_control  out  4  registered opcode to ALU
- alu_operand_1, alu_operand_2  out  32  registered operands to ALU
- alu_shamt  out  5  registered shift amount to ALU
- alu_result  in  32  ALU combinational result
- alu_status  in  8  {zero, overflow, carry, negative, invalid_address, div_zero, 0, 0}
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that issued the op
- rsp_result  out  32  captured result
- rsp_status  out  8  captured status
- err_clear  in  1  synchronous clear of err_count
- err_count  out  8  saturating count of overflow/div_zero responses

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Grant goes to the single valid requester. If both are valid, grant goes to rr_ptr.
  - reqN_ready = (state==IDLE) && grantN, combinational from the valids. At most one ready is high per cycle.
  - On accept: latch control/operands/shamt into the alu_* registers, record the id, set rr_ptr <= ~id, go to EXEC.
- **EXEC**
  - The ALU sees stable registered inputs.
  - At the clock edge, capture rsp_result <= alu_result, rsp_status <= alu_status, rsp_id <= id, and go to RESP.
  - Div-by-zero override: if alu_control==4'b0100 and alu_operand_2==0, force rsp_result=0 and rsp_status=8'h04. This keeps the response free of X.
- **RESP**
  - rsp_valid=1. rsp_result, rsp_status and rsp_id stay stable until rsp_valid && rsp_ready; then go to IDLE.
  - Both req_ready outputs stay low in EXEC and RESP.
- **err_count**
  - Increments by 1 on the EXEC capture edge when the captured status has bit 6 (overflow) or bit 2 (div_zero) set.
  - Saturates at 255.
  - err_clear has priority over a simultaneous increment; the result is 0.
- alu_* registers hold their last issued value while idle. No operation is issued without an accept.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0 (req0 favoured first).
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_status=0.
  - alu_control=0, alu_operand_1/2=0, alu_shamt=0.
  - err_count=0, req0_ready/req1_ready=0 in the reset cycle.
- Accept at edge k: EXEC during cycle k+1, rsp_valid high from cycle k+2.
- Minimum issue interval is 3 cycles: the earliest next accept is the cycle after the response handshake.
- Backpressure: while rsp_ready=0 in RESP, all rsp_* outputs hold and no request is accepted.
- Simultaneous valids at every IDLE cycle: grants alternate 0,1,0,1…
- A requester dropping valid without ready is legal; no state change occurs.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response. All registers return to reset values on that edge.
- err_clear and reset both take effect at the next edge regardless of state.

## Test plan
- req0 add (0010), 5 + 3 -> accept in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_result=8, rsp_status=8'h00; err_count stays 0.
- req1 sub (0110), 7 − 7 -> rsp_result=0, rsp_status=8'h80, rsp_id=1.
- req0 add 32'h7FFFFFFF + 1 -> rsp_result=32'h80000000, rsp_status=8'h50, err_count=1. Then req0 div 10 / 0 -> rsp_result=0, rsp_status=8'h04, err_count=2. Then err_clear -> err_count=0.
- Both requesters valid continuously after reset with rsp_ready=1 -> grant order 0,1,0,1; accepts every 3 cycles; each rsp_id matches its issuer.
- rsp_ready held low for 4 cycles in RESP -> rsp_valid and data stable, both req_ready low; the response completes on the cycle rsp_ready rises.
- reset asserted during EXEC -> next cycle rsp_valid=0, state IDLE, err_count=0; no response is ever produced for the dropped op.
